// File: rtl/bram_window_scheduler_if.sv
// Bundle of the scheduler's control, pixel-in, BRAM and column-triple-out signals.
interface bram_window_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 22,
  parameter int unsigned ADDR_W     = 18
);
  logic                  start;
  logic                  start_mode;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  bram_we;
  logic [ADDR_W-1:0]     bram_wr_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic [ADDR_W-1:0]     bram_rd_addr0;
  logic [ADDR_W-1:0]     bram_rd_addr1;
  logic [ADDR_W-1:0]     bram_rd_addr2;
  logic [DATA_WIDTH-1:0] bram_dout0;
  logic [DATA_WIDTH-1:0] bram_dout1;
  logic [DATA_WIDTH-1:0] bram_dout2;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_top;
  logic [DATA_WIDTH-1:0] out_mid;
  logic [DATA_WIDTH-1:0] out_bot;
  logic [ADDR_W-1:0]     out_col;
  logic [ADDR_W-1:0]     out_row;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  // Scheduler side: drives the BRAM ports and the triple stream.
  modport master (
    input  start, start_mode, in_valid, in_data,
    input  bram_dout0, bram_dout1, bram_dout2, out_ready,
    output in_ready, bram_we, bram_wr_addr, bram_din,
    output bram_rd_addr0, bram_rd_addr1, bram_rd_addr2,
    output out_valid, out_top, out_mid, out_bot, out_col, out_row, out_last,
    output busy, done
  );

  // Surroundings: pixel source, BRAM and window stage.
  modport slave (
    output start, start_mode, in_valid, in_data,
    output bram_dout0, bram_dout1, bram_dout2, out_ready,
    input  in_ready, bram_we, bram_wr_addr, bram_din,
    input  bram_rd_addr0, bram_rd_addr1, bram_rd_addr2,
    input  out_valid, out_top, out_mid, out_bot, out_col, out_row, out_last,
    input  busy, done
  );
endinterface

// File: rtl/bram_window_scheduler.sv
// Frame BRAM sequencer: fills one raster frame, then scans it issuing
// top/centre/bottom row reads and streams border-clamped column triples.
module bram_window_scheduler #(
  parameter int unsigned DATA_WIDTH = 22,
  parameter int unsigned IMG_W      = 384,
  parameter int unsigned IMG_H      = 384,
  parameter int unsigned ADDR_W     = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  bram_window_scheduler_if.master bus
);

  localparam int unsigned NPIX       = IMG_W * IMG_H;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned CNT_W      = 3;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_COL   = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] BASE2_INIT = (IMG_H > 1) ? ROW_STEP : '0;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SCAN, S_DRAIN} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic              last;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] top;
    logic [DATA_WIDTH-1:0] mid;
    logic [DATA_WIDTH-1:0] bot;
    tag_t                  tag;
  } entry_t;

  state_e            state_q, state_d;
  logic              in_ready_c, wr_en_c, issue_c, pop_c;
  logic              fill_last_c, col_last_c, row_last_c, last_pix_c;
  logic [CNT_W-1:0]  inflight_c, cnt_ap_c;

  logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
  logic [ADDR_W-1:0] base0_q, base0_d, base1_q, base1_d, base2_q, base2_d;
  logic [ADDR_W-1:0] rd0_q, rd0_d, rd1_q, rd1_d, rd2_q, rd2_d;
  logic              iss1_q, iss2_q;
  tag_t              tag1_q, tag1_d, tag2_q;

  entry_t            fifo_q [FIFO_DEPTH];
  entry_t            fifo_d [FIFO_DEPTH];
  entry_t            push_entry_c;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, busy_q, done_q;

  assign fill_last_c = (wr_cnt_q == LAST_ADDR);
  assign col_last_c  = (col_q == LAST_COL);
  assign row_last_c  = (row_q == LAST_ROW);
  assign last_pix_c  = col_last_c && row_last_c;
  assign inflight_c  = CNT_W'(iss1_q) + CNT_W'(iss2_q);
  assign pop_c       = out_valid_q && bus.out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = bus.start_mode ? S_SCAN : S_FILL;
      S_FILL:  if (wr_en_c && fill_last_c) state_d = S_SCAN;
      S_SCAN:  if (issue_c && last_pix_c) state_d = S_DRAIN;
      S_DRAIN: if ((cnt_q == '0) && !iss1_q && !iss2_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-state strobes: pixel accept/write in FILL, read issue in SCAN while FIFO room remains.
  always_comb begin
    in_ready_c = 1'b0;
    wr_en_c    = 1'b0;
    issue_c    = 1'b0;
    case (state_q)
      S_FILL: begin
        in_ready_c = 1'b1;
        wr_en_c    = bus.in_valid;
      end
      S_SCAN:  issue_c = (cnt_q + inflight_c) < CNT_W'(FIFO_DEPTH);
      default: ;
    endcase
  end

  // Write counter and scan position; row bases step by IMG_W with bottom row clamped.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    base0_d  = base0_q;
    base1_d  = base1_q;
    base2_d  = base2_q;
    rd0_d    = rd0_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    tag1_d   = tag1_q;
    if (state_q != S_FILL)  wr_cnt_d = '0;
    else if (wr_en_c)       wr_cnt_d = wr_cnt_q + ADDR_W'(1);
    if (state_q != S_SCAN) begin
      row_d   = '0;
      col_d   = '0;
      base0_d = '0;
      base1_d = '0;
      base2_d = BASE2_INIT;
    end else if (issue_c) begin
      rd0_d  = base0_q + col_q;
      rd1_d  = base1_q + col_q;
      rd2_d  = base2_q + col_q;
      tag1_d = '{row: row_q, col: col_q, last: last_pix_c};
      if (col_last_c) begin
        col_d   = '0;
        row_d   = row_q + ADDR_W'(1);
        base0_d = base1_q;
        base1_d = base1_q + ROW_STEP;
        if (32'(row_q) + 32'd2 < IMG_H) base2_d = base2_q + ROW_STEP;
      end else begin
        col_d = col_q + ADDR_W'(1);
      end
    end
  end

  // Counters, read-address registers and the two-stage tag pipeline matching BRAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      base0_q  <= '0;
      base1_q  <= '0;
      base2_q  <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      iss1_q   <= 1'b0;
      iss2_q   <= 1'b0;
      tag1_q   <= '0;
      tag2_q   <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      base0_q  <= base0_d;
      base1_q  <= base1_d;
      base2_q  <= base2_d;
      rd0_q    <= rd0_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      iss1_q   <= issue_c;
      iss2_q   <= iss1_q;
      tag1_q   <= tag1_d;
      tag2_q   <= tag1_q;
    end
  end

  assign push_entry_c = '{top: bus.bram_dout0, mid: bus.bram_dout1,
                          bot: bus.bram_dout2, tag: tag2_q};

  // Show-ahead FIFO with the head fixed at entry 0: pop shifts down, push lands after the survivors.
  always_comb begin
    fifo_d   = fifo_q;
    cnt_ap_c = cnt_q - CNT_W'(pop_c);
    if (pop_c) begin
      for (int unsigned i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
    end
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (iss2_q && (CNT_W'(i) == cnt_ap_c)) fifo_d[i] = push_entry_c;
    end
    cnt_d = cnt_ap_c + CNT_W'(iss2_q);
  end

  // FIFO storage and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      cnt_q       <= cnt_d;
      out_valid_q <= (cnt_d != '0);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= pop_c && fifo_q[0].tag.last;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.bram_we       = wr_en_c;
  assign bus.bram_wr_addr  = wr_cnt_q;
  assign bus.bram_din      = in_ready_c ? bus.in_data : '0;
  assign bus.bram_rd_addr0 = rd0_q;
  assign bus.bram_rd_addr1 = rd1_q;
  assign bus.bram_rd_addr2 = rd2_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_top       = fifo_q[0].top;
  assign bus.out_mid       = fifo_q[0].mid;
  assign bus.out_bot       = fifo_q[0].bot;
  assign bus.out_row       = fifo_q[0].tag.row;
  assign bus.out_col       = fifo_q[0].tag.col;
  assign bus.out_last      = fifo_q[0].tag.last;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

endmodule

// File: tb/tb_bram_window_scheduler.sv
// Bench for bram_window_scheduler on a 4x3 frame with a behavioural BRAM and triple scoreboard.
module tb_bram_window_scheduler;
  localparam int unsigned DW = 22;
  localparam int unsigned AW = 18;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bram_window_scheduler_if #(.DATA_WIDTH(DW), .ADDR_W(AW)) bus ();

  bram_window_scheduler #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame memory with one write port and three registered read ports.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (bus.bram_we) mem[bus.bram_wr_addr[7:0]] <= bus.bram_din;
    bus.bram_dout0 <= mem[bus.bram_rd_addr0[7:0]];
    bus.bram_dout1 <= mem[bus.bram_rd_addr1[7:0]];
    bus.bram_dout2 <= mem[bus.bram_rd_addr2[7:0]];
  end

  // Downstream ready: 0 = held low, 1 = held high, 2 = random 50%.
  int rdy_mode = 1;
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b0;
        1:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  typedef struct {
    longint top, mid, bot;
    int     row, col;
    bit     last;
    int     cyc;
  } trip_t;
  typedef struct {
    int     addr;
    longint data;
  } wr_t;

  trip_t acc_q[$];
  wr_t   wr_q[$];
  trip_t prev;
  int    cyc = 0;
  int    done_cnt = 0, done_cyc = -1, busy_fall_cyc = -1, we_bad = 0;
  bit    stall_prev = 0, busy_prev = 0;

  always @(posedge clk) cyc++;

  // Monitor: accepted triples, writes, done/busy timing and hold-under-stall.
  always @(negedge clk) begin
    trip_t cur;
    cur.top = bus.out_top; cur.mid = bus.out_mid; cur.bot = bus.out_bot;
    cur.row = int'(bus.out_row); cur.col = int'(bus.out_col);
    cur.last = bus.out_last; cur.cyc = cyc;
    if (!rst_n) begin
      stall_prev = 0;
      busy_prev  = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", longint'(bus.out_valid), 1);
        chk("hold_data", (cur.top == prev.top && cur.mid == prev.mid && cur.bot == prev.bot &&
                          cur.row == prev.row && cur.col == prev.col && cur.last == prev.last) ? 1 : 0, 1);
      end
      if (bus.out_valid && bus.out_ready) acc_q.push_back(cur);
      stall_prev = bus.out_valid && !bus.out_ready;
      prev = cur;
      if (bus.bram_we) begin
        wr_q.push_back('{addr: int'(bus.bram_wr_addr), data: longint'(bus.bram_din)});
        if (!bus.in_ready || !bus.in_valid) we_bad++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy_prev && !bus.busy) busy_fall_cyc = cyc;
      busy_prev = bus.busy;
    end
  end

  logic [DW-1:0] pix [N];

  typedef struct {
    int     idx;
    int     row, col;
    longint top, mid, bot;
    bit     last;
  } vec_t;
  vec_t tbl [N];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input bit mode);
    bus.start = 1'b1;
    bus.start_mode = mode;
    step();
    bus.start = 1'b0;
    bus.start_mode = 1'b0;
  endtask

  task automatic clear_mon();
    acc_q.delete();
    wr_q.delete();
    we_bad = 0;
    done_cyc = -1;
    busy_fall_cyc = -1;
  endtask

  // Present pix[] in raster order; vmode 0 = always valid, 1 = 1010.., 2 = random.
  task automatic stream(input int vmode);
    int i = 0;
    int guard = 0;
    bit v;
    while (i < N && guard < 400) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((guard % 2) == 0) : 1'($urandom_range(0, 1));
      bus.in_valid = v;
      bus.in_data  = v ? pix[i] : DW'($urandom);
      if (v && bus.in_ready) i++;
      step();
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("fill_complete", i, N);
  endtask

  task automatic wait_done(input string name);
    int start_cnt = done_cnt;
    int k = 0;
    while (done_cnt == start_cnt && k < 300) begin
      step();
      k++;
    end
    chk(name, done_cnt - start_cnt, 1);
    step(); step(); step();
    chk({name, "_once"}, done_cnt - start_cnt, 1);
    chk({name, "_busy_low"}, longint'(bus.busy), 0);
    chk({name, "_busy_fall"}, busy_fall_cyc - done_cyc, 1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_wr_count"}, wr_q.size(), N);
    for (int i = 0; i < N && i < wr_q.size(); i++) begin
      chk($sformatf("%s_wr_addr[%0d]", tag, i), wr_q[i].addr, i);
      chk($sformatf("%s_wr_data[%0d]", tag, i), wr_q[i].data, longint'(pix[i]));
    end
    chk({tag, "_we_outside_fill"}, we_bad, 0);
  endtask

  // Reference: triple k is column k%W of rows clamp(r-1), r, clamp(r+1) of the stored frame.
  task automatic check_scan(input string tag);
    chk({tag, "_triples"}, acc_q.size(), N);
    for (int k = 0; k < N && k < acc_q.size(); k++) begin
      int r = k / W;
      int c = k % W;
      int rt = (r == 0) ? 0 : r - 1;
      int rb = (r == H - 1) ? H - 1 : r + 1;
      longint et = longint'(pix[rt * W + c]);
      longint em = longint'(pix[r * W + c]);
      longint eb = longint'(pix[rb * W + c]);
      bit el = (k == N - 1);
      trip_t g = acc_q[k];
      checks++;
      if (g.top != et || g.mid != em || g.bot != eb || g.row != r || g.col != c || g.last != el) begin
        errors++;
        $display("FAIL %s_triple[%0d]: got t=%0d m=%0d b=%0d r=%0d c=%0d l=%0d expected t=%0d m=%0d b=%0d r=%0d c=%0d l=%0d",
                 tag, k, g.top, g.mid, g.bot, g.row, g.col, g.last, et, em, eb, r, c, el);
      end
    end
  endtask

  task automatic check_outs_zero(input string tag);
    int nz;
    nz = int'(bus.out_valid != 0) + int'(bus.busy != 0) + int'(bus.done != 0) +
         int'(bus.in_ready != 0) + int'(bus.bram_we != 0) + int'(bus.bram_wr_addr != 0) +
         int'(bus.bram_din != 0) + int'(bus.bram_rd_addr0 != 0) + int'(bus.bram_rd_addr1 != 0) +
         int'(bus.bram_rd_addr2 != 0) + int'(bus.out_top != 0) + int'(bus.out_mid != 0) +
         int'(bus.out_bot != 0) + int'(bus.out_row != 0) + int'(bus.out_col != 0) +
         int'(bus.out_last != 0);
    chk({tag, "_nonzero_outputs"}, nz, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int b2b;
    int dsave;
    int guard;
    tbl[0]  = '{0,  0, 0, 0, 0, 4, 0};
    tbl[1]  = '{1,  0, 1, 1, 1, 5, 0};
    tbl[2]  = '{2,  0, 2, 2, 2, 6, 0};
    tbl[3]  = '{3,  0, 3, 3, 3, 7, 0};
    tbl[4]  = '{4,  1, 0, 0, 4, 8, 0};
    tbl[5]  = '{5,  1, 1, 1, 5, 9, 0};
    tbl[6]  = '{6,  1, 2, 2, 6, 10, 0};
    tbl[7]  = '{7,  1, 3, 3, 7, 11, 0};
    tbl[8]  = '{8,  2, 0, 4, 8, 8, 0};
    tbl[9]  = '{9,  2, 1, 5, 9, 9, 0};
    tbl[10] = '{10, 2, 2, 6, 10, 10, 0};
    tbl[11] = '{11, 2, 3, 7, 11, 11, 1};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.start_mode = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    step(); step();
    check_outs_zero("reset");
    rst_n = 1'b1;
    step();

    // Fill then scan, pixel = address, downstream always ready.
    for (int i = 0; i < N; i++) pix[i] = DW'(i);
    clear_mon();
    rdy_mode = 1;
    do_start(1'b0);
    stream(0);
    wait_done("A_done");
    check_writes("A");
    chk("A_triples", acc_q.size(), N);
    for (int k = 0; k < N && k < acc_q.size(); k++) begin
      checks++;
      if (acc_q[k].top != tbl[k].top || acc_q[k].mid != tbl[k].mid || acc_q[k].bot != tbl[k].bot ||
          acc_q[k].row != tbl[k].row || acc_q[k].col != tbl[k].col || acc_q[k].last != tbl[k].last) begin
        errors++;
        $display("FAIL A_vec[%0d]: got t=%0d m=%0d b=%0d r=%0d c=%0d l=%0d expected t=%0d m=%0d b=%0d r=%0d c=%0d l=%0d",
                 tbl[k].idx, acc_q[k].top, acc_q[k].mid, acc_q[k].bot, acc_q[k].row, acc_q[k].col,
                 acc_q[k].last, tbl[k].top, tbl[k].mid, tbl[k].bot, tbl[k].row, tbl[k].col, tbl[k].last);
      end
    end

    // Same frame with in_valid toggling 1010..
    clear_mon();
    do_start(1'b0);
    stream(1);
    wait_done("B_done");
    check_writes("B");
    check_scan("B");

    // Scan only with downstream stalled: four reads, then hold; start mid-scan ignored.
    clear_mon();
    rdy_mode = 0;
    do_start(1'b1);
    repeat (12) step();
    chk("C_stall_addr0", longint'(bus.bram_rd_addr0), 3);
    chk("C_stall_addr1", longint'(bus.bram_rd_addr1), 3);
    chk("C_stall_addr2", longint'(bus.bram_rd_addr2), 7);
    chk("C_stall_valid", longint'(bus.out_valid), 1);
    chk("C_stall_top", longint'(bus.out_top), 0);
    chk("C_stall_mid", longint'(bus.out_mid), 0);
    chk("C_stall_bot", longint'(bus.out_bot), 4);
    do_start(1'b0);
    step();
    chk("C_ignored_start_in_ready", longint'(bus.in_ready), 0);
    chk("C_busy_during_stall", longint'(bus.busy), 1);
    chk("C_no_accepts_while_stalled", acc_q.size(), 0);
    rdy_mode = 1;
    wait_done("C_done");
    check_scan("C");
    b2b = (acc_q.size() == N) ? acc_q[N-1].cyc - acc_q[0].cyc : -1;
    chk("C_back_to_back_span", b2b, N - 1);
    chk("C_no_writes", wr_q.size(), 0);

    // Scan only: first-valid latency, then reset after five triples.
    clear_mon();
    rdy_mode = 1;
    do_start(1'b1);
    chk("D_valid_lat1", longint'(bus.out_valid), 0);
    step(); step();
    chk("D_valid_lat3", longint'(bus.out_valid), 0);
    step();
    chk("D_valid_lat4", longint'(bus.out_valid), 1);
    chk("D_first_bot", longint'(bus.out_bot), 4);
    chk("D_first_row_col", longint'({bus.out_row, bus.out_col}), 0);
    guard = 0;
    while (acc_q.size() < 5 && guard < 50) begin
      step();
      guard++;
    end
    chk("D_reached_5", (acc_q.size() >= 5) ? 1 : 0, 1);
    dsave = done_cnt;
    rst_n = 1'b0;
    #2;
    check_outs_zero("D_midscan_reset");
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("D_no_done_after_reset", done_cnt - dsave, 0);
    chk("D_idle_after_reset", longint'(bus.busy), 0);
    clear_mon();
    rdy_mode = 2;
    do_start(1'b1);
    wait_done("D_done");
    check_scan("D");

    // Random pixels, random valid and random ready.
    for (int i = 0; i < N; i++) pix[i] = DW'($urandom);
    clear_mon();
    do_start(1'b0);
    stream(2);
    wait_done("E_done");
    check_writes("E");
    check_scan("E");

    // Rescan of the random frame under random ready.
    clear_mon();
    do_start(1'b1);
    wait_done("F_done");
    check_scan("F");
    chk("F_no_writes", wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
